// File: rtl/mlp_98.sv
// -----------------------------------------------------------------------------
// mlp_98 -- fully pipelined 2-layer integer MLP, one 98-feature vector per clock
//
// Scores 49 unsigned magnitudes plus 49 polarity bits through N2 ReLU hidden
// neurons and a single signed output neuron. There is no handshake and no
// backpressure: the inputs are sampled on every rising edge and the result of
// the vector sampled on edge t is on out after edge t + LAT, LAT = D1 + D2 + 2.
//
// Ports
//   clk        in   1                 rising-edge clock
//   rstn       in   1                 synchronous active-low reset, clears the
//                                     whole pipeline including out
//   in_mag     in   [N1/2][W_X]       magnitudes x[i], unsigned
//   in_pol     in   [N1/2]            polarity bits p[i]
//   in_valid   in   1                 (MLP_98_VALID_EN only) tag for the vector
//   out_valid  out  1                 (MLP_98_VALID_EN only) in_valid aligned to out
//   out        out  W_Y_SUM           signed score y
//
// Configuration macro
//   MLP_98_VALID_EN  adds in_valid/out_valid and a matching tag shift register.
//                    The datapath is the same whether or not it is defined.
// -----------------------------------------------------------------------------
module mlp_98 #(
   parameter int N1  = 98,
   parameter int N2  = 20,
   parameter int W_X = 4,
   parameter int W_K = 4,
   parameter int D1  = $clog2(N1/2),
   parameter int D2  = $clog2(N2),
   parameter logic [N2*(N1/2)*W_K-1:0] K1_MAG = {(N2*(N1/2)){W_K'(1)}},
   parameter logic [N2*(N1/2)*W_K-1:0] K1_POL = {(N2*(N1/2)){W_K'(1)}},
   parameter logic [N2*W_K-1:0]        K2     = {N2{W_K'(1)}},
   localparam int W_A_SUM = W_X + W_K + $clog2(N1/2),
   localparam int W_Y_SUM = W_A_SUM + W_K + $clog2(N2)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [N1/2-1:0][W_X-1:0]      in_mag,
   input  logic [N1/2-1:0]               in_pol,
`ifdef MLP_98_VALID_EN
   input  logic                          in_valid,
   output logic                          out_valid,
`endif
   output logic signed [W_Y_SUM-1:0]     out
);

   localparam int NH = N1 / 2;

   // Adder-tree levels are padded to an even width. Padding slots hold zero,
   // so an odd element is summed with zero and simply passes through, and the
   // levels beyond $clog2 degenerate into plain delay registers.
   localparam int NP1 = ((NH + 1) / 2) * 2;
   localparam int NP2 = ((N2 + 1) / 2) * 2;

   // ---------------------------------------------------------------------------
   // Stage 0: input register
   // ---------------------------------------------------------------------------
   logic [NH-1:0][W_X-1:0] mag_q;
   logic [NH-1:0]          pol_q;

   // NOTE: sequential state is written with <= so every register samples the
   // pre-edge value of its source, regardless of process order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mag_q <= '0;
         pol_q <= '0;
      end else begin
         mag_q <= in_mag;
         pol_q <= in_pol;
      end
   end

   // ---------------------------------------------------------------------------
   // Layer 1: per-feature terms, then D1 pairwise adder stages per neuron.
   // l1_in[j][k] is the input of adder stage k, l1_q[j][k] its registered sum.
   // ---------------------------------------------------------------------------
   logic signed [W_A_SUM-1:0] l1_in [N2][D1][NP1];
   logic signed [W_A_SUM-1:0] l1_q  [N2][D1][NP1];

   // NOTE: every variable of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      logic signed [W_A_SUM-1:0] x_ext, w_mag, w_pol, p_term;
      l1_in  = '{default: '0};
      x_ext  = '0;
      w_mag  = '0;
      w_pol  = '0;
      p_term = '0;
      for (int j = 0; j < N2; j++) begin
         for (int i = 0; i < NH; i++) begin
            // Magnitude zero-extends, weights sign-extend.
            x_ext  = W_A_SUM'(mag_q[i]);
            w_mag  = W_A_SUM'($signed(K1_MAG[(j*NH + i)*W_K +: W_K]));
            w_pol  = W_A_SUM'($signed(K1_POL[(j*NH + i)*W_K +: W_K]));
            p_term = pol_q[i] ? w_pol : '0;
            l1_in[j][0][i] = x_ext * w_mag + p_term;
         end
         for (int k = 1; k < D1; k++) begin
            for (int i = 0; i < NP1; i++) begin
               l1_in[j][k][i] = l1_q[j][k-1][i];
            end
         end
      end
   end

   // NOTE: these arrays are pipeline registers rather than storage, so they
   // are cleared on reset together with the rest of the datapath.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         l1_q <= '{default: '0};
      end else begin
         for (int j = 0; j < N2; j++) begin
            for (int k = 0; k < D1; k++) begin
               for (int i = 0; i < NP1/2; i++) begin
                  l1_q[j][k][i] <= l1_in[j][k][2*i] + l1_in[j][k][2*i+1];
               end
               for (int i = NP1/2; i < NP1; i++) begin
                  l1_q[j][k][i] <= '0;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Hidden register: ReLU of each neuron's pre-activation a[j]
   // ---------------------------------------------------------------------------
   logic signed [W_A_SUM-1:0] h_q [N2];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         h_q <= '{default: '0};
      end else begin
         for (int j = 0; j < N2; j++) begin
            h_q[j] <= l1_q[j][D1-1][0][W_A_SUM-1] ? '0 : l1_q[j][D1-1][0];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Layer 2: weighted hidden terms, then D2 pairwise adder stages
   // ---------------------------------------------------------------------------
   logic signed [W_Y_SUM-1:0] l2_in [D2][NP2];
   logic signed [W_Y_SUM-1:0] l2_q  [D2][NP2];

   always_comb begin
      logic signed [W_Y_SUM-1:0] h_ext, w_out;
      l2_in = '{default: '0};
      h_ext = '0;
      w_out = '0;
      for (int j = 0; j < N2; j++) begin
         h_ext = W_Y_SUM'(h_q[j]);
         w_out = W_Y_SUM'($signed(K2[j*W_K +: W_K]));
         l2_in[0][j] = h_ext * w_out;
      end
      for (int k = 1; k < D2; k++) begin
         for (int i = 0; i < NP2; i++) begin
            l2_in[k][i] = l2_q[k-1][i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         l2_q <= '{default: '0};
      end else begin
         for (int k = 0; k < D2; k++) begin
            for (int i = 0; i < NP2/2; i++) begin
               l2_q[k][i] <= l2_in[k][2*i] + l2_in[k][2*i+1];
            end
            for (int i = NP2/2; i < NP2; i++) begin
               l2_q[k][i] <= '0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out <= '0;
      end else begin
         out <= l2_q[D2-1][0];
      end
   end

`ifdef MLP_98_VALID_EN
   // Tag pipeline: LAT + 1 flops so that bit 0 lines up with stage 0 and the
   // last bit lines up with out.
   localparam int LAT = D1 + D2 + 2;

   logic [LAT:0] vld_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[LAT-1:0], in_valid};
      end
   end

   assign out_valid = vld_q[LAT];
`endif

endmodule

// File: tb/tb_mlp_98.sv
// -----------------------------------------------------------------------------
// tb_mlp_98 -- self-checking bench for mlp_98
//
// Three instances share one stimulus stream: default weights, K2 all -1, and
// K1_MAG all -1. Each driven vector pushes its expected scores onto a
// scoreboard queue; once the queue spans the pipeline the oldest entry is
// popped and compared against the outputs, which fixes the latency exactly.
// -----------------------------------------------------------------------------
module tb_mlp_98;

   localparam int NH  = 49;
   localparam int N2  = 20;
   localparam int W_Y = 23;
   localparam int LAT = 13;

   localparam logic [N2*NH*4-1:0] K1_NEG = {(N2*NH){4'hF}};
   localparam logic [N2*4-1:0]    K2_NEG = {N2{4'hF}};

   typedef logic [NH-1:0][3:0] mag_t;
   typedef logic [NH-1:0]      pol_t;

   typedef struct {
      logic signed [W_Y-1:0] ya;
      logic signed [W_Y-1:0] yb;
      logic signed [W_Y-1:0] yc;
      logic                  v;
   } exp_t;

   logic                  clk    = 1'b0;
   logic                  rstn   = 1'b0;
   mag_t                  in_mag = '0;
   pol_t                  in_pol = '0;
   logic signed [W_Y-1:0] out_a, out_b, out_c;

   exp_t  sb [$];
   int    n_pass  = 0;
   int    n_total = 0;
   int    cyc     = 0;
   string cur     = "none";

`ifdef MLP_98_VALID_EN
   logic in_valid = 1'b0;
   logic out_valid_a, out_valid_b, out_valid_c;
`endif

   always #5 clk = ~clk;

   mlp_98 dut_a (
      .clk      (clk),
      .rstn     (rstn),
      .in_mag   (in_mag),
      .in_pol   (in_pol),
`ifdef MLP_98_VALID_EN
      .in_valid (in_valid),
      .out_valid(out_valid_a),
`endif
      .out      (out_a)
   );

   mlp_98 #(.K2(K2_NEG)) dut_b (
      .clk      (clk),
      .rstn     (rstn),
      .in_mag   (in_mag),
      .in_pol   (in_pol),
`ifdef MLP_98_VALID_EN
      .in_valid (in_valid),
      .out_valid(out_valid_b),
`endif
      .out      (out_b)
   );

   mlp_98 #(.K1_MAG(K1_NEG)) dut_c (
      .clk      (clk),
      .rstn     (rstn),
      .in_mag   (in_mag),
      .in_pol   (in_pol),
`ifdef MLP_98_VALID_EN
      .in_valid (in_valid),
      .out_valid(out_valid_c),
`endif
      .out      (out_c)
   );

   // Reference score for uniform weights: every hidden neuron sees the same
   // pre-activation, so y = N2 * relu(a) * k2.
   function automatic logic signed [W_Y-1:0] model_y(input mag_t m, input pol_t p,
                                                     input int wm, input int wp, input int k2);
      int a;
      a = 0;
      for (int i = 0; i < NH; i++) begin
         a += int'(m[i]) * wm + (p[i] ? wp : 0);
      end
      if (a < 0) a = 0;
      return W_Y'(N2 * a * k2);
   endfunction

   // One clock of stimulus: compare the oldest pending result, then drive the
   // next vector and record what it must produce. A reset cycle wipes every
   // result still in flight, including the vector driven alongside it.
   task automatic step(input mag_t m, input pol_t p, input logic r, input logic v);
      exp_t e;
      @(negedge clk);
      cyc++;
      if (sb.size() == LAT + 1) begin
         e = sb.pop_front();
         n_total++;
         if (out_a !== e.ya) $display("FAIL %s out_a cycle %0d: got %0d expected %0d", cur, cyc, out_a, e.ya);
         else n_pass++;
         n_total++;
         if (out_b !== e.yb) $display("FAIL %s out_b cycle %0d: got %0d expected %0d", cur, cyc, out_b, e.yb);
         else n_pass++;
         n_total++;
         if (out_c !== e.yc) $display("FAIL %s out_c cycle %0d: got %0d expected %0d", cur, cyc, out_c, e.yc);
         else n_pass++;
`ifdef MLP_98_VALID_EN
         n_total++;
         if (out_valid_a !== e.v) $display("FAIL %s out_valid cycle %0d: got %0b expected %0b", cur, cyc, out_valid_a, e.v);
         else n_pass++;
`endif
      end
      rstn   = r;
      in_mag = m;
      in_pol = p;
`ifdef MLP_98_VALID_EN
      in_valid = v;
`endif
      if (!r) begin
         foreach (sb[k]) sb[k] = '{ya: '0, yb: '0, yc: '0, v: 1'b0};
      end
      e.ya = r ? model_y(m, p,  1, 1,  1) : '0;
      e.yb = r ? model_y(m, p,  1, 1, -1) : '0;
      e.yc = r ? model_y(m, p, -1, 1,  1) : '0;
      e.v  = r & v;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      cur = "reset";
      repeat (LAT + 3) step('0, '0, 1'b0, 1'b1);
      n_total++;
      if (out_a !== '0) $display("FAIL reset_out_a: got %0d expected 0", out_a);
      else n_pass++;
      n_total++;
      if (out_b !== '0 || out_c !== '0) $display("FAIL reset_out_bc: got %0d/%0d expected 0/0", out_b, out_c);
      else n_pass++;
   endtask

   task automatic test_zero();
      cur = "zero_input";
      repeat (20) step('0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_full();
      cur = "full_scale";
      step('1, '1, 1'b1, 1'b0);
      repeat (3) step('0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_single();
      mag_t m;
      pol_t p;
      cur = "single_feature";
      m = '0; p = '0; m[0] = 4'd3;
      step(m, p, 1'b1, 1'b0);
      m = '0; p = '0; m[NH-1] = 4'd1; p[NH-1] = 1'b1;
      step(m, p, 1'b1, 1'b0);
      step('0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_relu();
      cur = "relu_clamp";
      step('1, '0, 1'b1, 1'b0);
      step('0, '1, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      mag_t m;
      pol_t p;
      cur = "random";
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < NH; i++) begin
            m[i] = 4'($urandom_range(0, 15));
            p[i] = 1'($urandom_range(0, 1));
         end
         step(m, p, 1'b1, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      mag_t m;
      cur = "back_to_back";
      m = '0; m[0] = 4'd3;
      step('1, '1, 1'b1, 1'b0);
      step(m, '0, 1'b1, 1'b0);
      step('0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      cur = "reset_mid_stream";
      repeat (6) step('1, '1, 1'b1, 1'b1);
      step('1, '1, 1'b0, 1'b1);
      repeat (LAT + 4) step('1, '1, 1'b1, 1'b0);
   endtask

   task automatic test_valid();
      cur = "valid_tag";
      step('0, '0, 1'b1, 1'b1);
      repeat (4) step('0, '0, 1'b1, 1'b0);
      step('1, '0, 1'b1, 1'b1);
      step('1, '0, 1'b1, 1'b1);
      step('0, '0, 1'b1, 1'b0);
   endtask

   task automatic drain();
      cur = "drain";
      repeat (LAT + 2) step('0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_zero();
      test_full();
      test_single();
      test_relu();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_valid();
      drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
